// File: rtl/mlp_axis_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mlp_axis_pkg
//  Description : Shared AXI-Stream beat definition and default widths for the
//                MLP stage links.
//  Revision    : 1.0 - initial release
// ============================================================================
package mlp_axis_pkg;

    localparam int unsigned c_DATAW = 512;
    localparam int unsigned c_IDW   = 32;
    localparam int unsigned c_USERW = 75;
    localparam int unsigned c_DESTW = 32;
    localparam int unsigned c_DEPTH = 4;
    localparam int unsigned c_CNTW  = 32;

    // One beat at the default widths; field order is also the packing order
    // used for the flat FIFO word (data in the MSBs, dest in the LSBs).
    typedef struct packed {
        logic [c_DATAW-1:0] data;
        logic               last;
        logic [c_IDW-1:0]   id;
        logic [c_USERW-1:0] user;
        logic [c_DESTW-1:0] dest;
    } axis_beat_t;

    localparam int unsigned c_BEATW = $bits(axis_beat_t);

    // Flat beat width for arbitrary field widths.
    function automatic int unsigned beat_width(input int unsigned dw,
                                               input int unsigned iw,
                                               input int unsigned uw,
                                               input int unsigned sw);
        return dw + 1 + iw + uw + sw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_link_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_link_fifo
//  Description : Power-of-two FIFO with registered ready, registered
//                first-word-fall-through output and an occupancy count that
//                includes the beat currently presented at the output.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_link_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [W-1:0]               i_data,
    output logic                       o_valid,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int unsigned c_PTRW = $clog2(DEPTH);
    localparam int unsigned c_LVLW = $clog2(DEPTH+1);
    localparam logic [c_LVLW-1:0] c_FULL = c_LVLW'(DEPTH);

    logic [W-1:0]      r_mem [DEPTH];
    logic [c_PTRW-1:0] r_wptr;
    logic [c_PTRW-1:0] r_rptr;
    logic [c_LVLW-1:0] r_level;
    logic              r_ready;
    logic              r_valid;
    logic [W-1:0]      r_out;

    logic              w_push;
    logic              w_pop;
    logic [c_PTRW-1:0] w_wptr_n;
    logic [c_PTRW-1:0] w_rptr_n;
    logic [c_LVLW-1:0] w_level_n;
    logic [W-1:0]      w_head_n;

    assign w_push    = i_valid & r_ready;
    assign w_pop     = i_pop & r_valid;
    assign w_wptr_n  = r_wptr + c_PTRW'(w_push);
    assign w_rptr_n  = r_rptr + c_PTRW'(w_pop);
    assign w_level_n = r_level + c_LVLW'(w_push) - c_LVLW'(w_pop);
    // The next head is the beat being written this cycle when it lands on the
    // head slot (FIFO empty, or one entry left and it is popping).
    assign w_head_n  = (w_push && (r_wptr == w_rptr_n)) ? i_data : r_mem[w_rptr_n];

    // Storage array; contents need no reset because LEVEL gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers, occupancy, registered ready and registered head output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            r_wptr  <= w_wptr_n;
            r_rptr  <= w_rptr_n;
            r_level <= w_level_n;
            // Computed from the next level so a pop while full only frees
            // the slave side on the following cycle.
            r_ready <= (w_level_n != c_FULL);
            r_valid <= (w_level_n != '0);
            if (w_level_n != '0) begin
                r_out <= w_head_n;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_out;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/axis_stage_link.sv
`default_nettype none
// ============================================================================
//  Module      : axis_stage_link
//  Description : AXI-Stream link between MLP stages: buffering FIFO, optional
//                TDEST rewrite, beat/packet debug counters.
//                Define AXIS_STAGE_LINK_PKT_GATE_EN for store-and-forward
//                gating of the master TVALID (with full-FIFO cut-through
//                escape); undefined gives pure cut-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_stage_link
    import mlp_axis_pkg::*;
#(
    parameter int unsigned      DATAW        = c_DATAW,
    parameter int unsigned      IDW          = c_IDW,
    parameter int unsigned      USERW        = c_USERW,
    parameter int unsigned      DESTW        = c_DESTW,
    parameter int unsigned      DEPTH        = c_DEPTH,
    parameter int unsigned      REWRITE_DEST = 0,
    parameter logic [DESTW-1:0] NEXT_DEST    = '0,
    parameter int unsigned      CNTW         = c_CNTW
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       AXIS_S_TVALID,
    output logic                       AXIS_S_TREADY,
    input  logic [DATAW-1:0]           AXIS_S_TDATA,
    input  logic                       AXIS_S_TLAST,
    input  logic [IDW-1:0]             AXIS_S_TID,
    input  logic [USERW-1:0]           AXIS_S_TUSER,
    input  logic [DESTW-1:0]           AXIS_S_TDEST,
    output logic                       AXIS_M_TVALID,
    input  logic                       AXIS_M_TREADY,
    output logic [DATAW-1:0]           AXIS_M_TDATA,
    output logic                       AXIS_M_TLAST,
    output logic [IDW-1:0]             AXIS_M_TID,
    output logic [USERW-1:0]           AXIS_M_TUSER,
    output logic [DESTW-1:0]           AXIS_M_TDEST,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL,
    output logic [CNTW-1:0]            BEAT_CNT,
    output logic [CNTW-1:0]            PKT_CNT
);

    localparam int unsigned c_BW   = beat_width(DATAW, IDW, USERW, DESTW);
    localparam int unsigned c_LVLW = $clog2(DEPTH+1);

    logic [DESTW-1:0]  w_s_dest;
    logic [c_BW-1:0]   w_s_beat;
    logic [c_BW-1:0]   w_m_beat;
    logic              w_fifo_valid;
    logic              w_gate;
    logic              w_m_valid;
    logic              w_push;
    logic              w_pop;
    logic [c_LVLW-1:0] w_level;
    logic [CNTW-1:0]   r_beat_cnt;
    logic [CNTW-1:0]   r_pkt_cnt;

    // Rewriting on the way in keeps the registered output at zero in reset.
    generate
        if (REWRITE_DEST != 0) begin : g_dest_rewrite
            assign w_s_dest = NEXT_DEST;
        end else begin : g_dest_pass
            assign w_s_dest = AXIS_S_TDEST;
        end
    endgenerate

    assign w_s_beat = {AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TUSER, w_s_dest};

    axis_link_fifo #(
        .W     (c_BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_valid (AXIS_S_TVALID),
        .o_ready (AXIS_S_TREADY),
        .i_data  (w_s_beat),
        .o_valid (w_fifo_valid),
        .i_pop   (w_pop),
        .o_data  (w_m_beat),
        .o_level (w_level)
    );

    assign {AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TUSER, AXIS_M_TDEST} = w_m_beat;

    assign w_push        = AXIS_S_TVALID & AXIS_S_TREADY;
    assign w_m_valid     = w_fifo_valid & w_gate;
    assign w_pop         = w_m_valid & AXIS_M_TREADY;
    assign AXIS_M_TVALID = w_m_valid;
    assign LEVEL         = w_level;

`ifdef AXIS_STAGE_LINK_PKT_GATE_EN
    localparam logic [c_LVLW-1:0] c_FULL = c_LVLW'(DEPTH);

    logic [c_LVLW-1:0] r_pkts;
    logic              r_cut;

    // A full FIFO holding no TLAST can never complete a packet, so the gate
    // opens immediately and stays open (r_cut) until the next TLAST pops.
    assign w_gate = (r_pkts != '0) || r_cut || ((w_level == c_FULL) && (r_pkts == '0));

    // Resident complete-packet count and the cut-through escape latch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pkts <= '0;
            r_cut  <= 1'b0;
        end else begin
            r_pkts <= r_pkts + c_LVLW'(w_push & AXIS_S_TLAST) - c_LVLW'(w_pop & AXIS_M_TLAST);
            if (w_pop && AXIS_M_TLAST) begin
                r_cut <= 1'b0;
            end else if ((w_level == c_FULL) && (r_pkts == '0)) begin
                r_cut <= 1'b1;
            end
        end
    end
`else
    assign w_gate = 1'b1;
`endif

    // Debug counters of beats and packets leaving on the master side.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + CNTW'(1);
            if (AXIS_M_TLAST) begin
                r_pkt_cnt <= r_pkt_cnt + CNTW'(1);
            end
        end
    end

    assign BEAT_CNT = r_beat_cnt;
    assign PKT_CNT  = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_stage_link.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_stage_link
//  Description : Scoreboard bench for axis_stage_link. Two instances share
//                stimulus: u0 rewrites TDEST to NEXT_DEST, u1 forwards it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_stage_link;

    localparam int DATAW = 32;
    localparam int IDW   = 8;
    localparam int USERW = 12;
    localparam int DESTW = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;
    localparam int LVLW  = $clog2(DEPTH+1);
    localparam logic [DESTW-1:0] NEXT_DEST = 8'h02;

    typedef struct {
        logic [DATAW-1:0] data;
        logic             last;
        logic [IDW-1:0]   id;
        logic [USERW-1:0] user;
        logic [DESTW-1:0] dest;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic [DATAW-1:0] s_data;
    logic             s_last;
    logic [IDW-1:0]   s_id;
    logic [USERW-1:0] s_user;
    logic [DESTW-1:0] s_dest;
    logic             m_ready;

    logic             s_ready0, m_valid0, m_last0, s_ready1, m_valid1, m_last1;
    logic [DATAW-1:0] m_data0, m_data1;
    logic [IDW-1:0]   m_id0, m_id1;
    logic [USERW-1:0] m_user0, m_user1;
    logic [DESTW-1:0] m_dest0, m_dest1;
    logic [LVLW-1:0]  lvl0, lvl1;
    logic [CNTW-1:0]  beat0, pkt0, beat1, pkt1;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_beats = 0;
    int    exp_pkts = 0;
    bit    mon_en = 1'b0;
    int    rdy_mode = 0;
    int    stalls = 0;

    axis_stage_link #(
        .DATAW(DATAW), .IDW(IDW), .USERW(USERW), .DESTW(DESTW), .DEPTH(DEPTH),
        .REWRITE_DEST(1), .NEXT_DEST(NEXT_DEST), .CNTW(CNTW)
    ) u0 (
        .CLK(clk), .RST_N(rst_n),
        .AXIS_S_TVALID(s_valid), .AXIS_S_TREADY(s_ready0), .AXIS_S_TDATA(s_data),
        .AXIS_S_TLAST(s_last), .AXIS_S_TID(s_id), .AXIS_S_TUSER(s_user), .AXIS_S_TDEST(s_dest),
        .AXIS_M_TVALID(m_valid0), .AXIS_M_TREADY(m_ready), .AXIS_M_TDATA(m_data0),
        .AXIS_M_TLAST(m_last0), .AXIS_M_TID(m_id0), .AXIS_M_TUSER(m_user0), .AXIS_M_TDEST(m_dest0),
        .LEVEL(lvl0), .BEAT_CNT(beat0), .PKT_CNT(pkt0)
    );

    axis_stage_link #(
        .DATAW(DATAW), .IDW(IDW), .USERW(USERW), .DESTW(DESTW), .DEPTH(DEPTH),
        .REWRITE_DEST(0), .NEXT_DEST(NEXT_DEST), .CNTW(CNTW)
    ) u1 (
        .CLK(clk), .RST_N(rst_n),
        .AXIS_S_TVALID(s_valid), .AXIS_S_TREADY(s_ready1), .AXIS_S_TDATA(s_data),
        .AXIS_S_TLAST(s_last), .AXIS_S_TID(s_id), .AXIS_S_TUSER(s_user), .AXIS_S_TDEST(s_dest),
        .AXIS_M_TVALID(m_valid1), .AXIS_M_TREADY(m_ready), .AXIS_M_TDATA(m_data1),
        .AXIS_M_TLAST(m_last1), .AXIS_M_TID(m_id1), .AXIS_M_TUSER(m_user1), .AXIS_M_TDEST(m_dest1),
        .LEVEL(lvl1), .BEAT_CNT(beat1), .PKT_CNT(pkt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [DATAW-1:0] d, input logic l, input logic [DESTW-1:0] dst);
        beat_t b;
        b.data = d;
        b.last = l;
        b.id   = IDW'($urandom);
        b.user = USERW'($urandom);
        b.dest = dst;
        return b;
    endfunction

    // Sink ready: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode == 0)      m_ready = 1'b1;
            else if (rdy_mode == 1) m_ready = 1'b0;
            else                    m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: model state checks, then pop the scoreboard on each handshake.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("level", 64'(lvl0), 64'(q.size()));
                chk("level_u1", 64'(lvl1), 64'(q.size()));
                chk("s_ready", 64'(s_ready0), 64'(q.size() != DEPTH));
                chk("s_ready_u1", 64'(s_ready1), 64'(q.size() != DEPTH));
`ifndef AXIS_STAGE_LINK_PKT_GATE_EN
                chk("m_valid", 64'(m_valid0), 64'(q.size() != 0));
                chk("m_valid_u1", 64'(m_valid1), 64'(q.size() != 0));
`endif
                chk("beat_cnt", 64'(beat0), 64'(CNTW'(exp_beats)));
                chk("pkt_cnt", 64'(pkt0), 64'(CNTW'(exp_pkts)));
                chk("beat_cnt_u1", 64'(beat1), 64'(CNTW'(exp_beats)));
                if (m_valid0) begin
                    if (q.size() == 0) begin
                        chk("valid_with_empty_model", 64'(m_valid0), 64'd0);
                    end else begin
                        e = q[0];
                        chk("tdata", 64'(m_data0), 64'(e.data));
                        chk("tlast", 64'(m_last0), 64'(e.last));
                        chk("tid", 64'(m_id0), 64'(e.id));
                        chk("tuser", 64'(m_user0), 64'(e.user));
                        chk("tdest_rewrite", 64'(m_dest0), 64'(NEXT_DEST));
                        chk("tdata_u1", 64'(m_data1), 64'(e.data));
                        chk("tdest_forward", 64'(m_dest1), 64'(e.dest));
                        if (m_ready) begin
                            void'(q.pop_front());
                            exp_beats++;
                            if (e.last) exp_pkts++;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input beat_t b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b.data;
        s_last  = b.last;
        s_id    = b.id;
        s_user  = b.user;
        s_dest  = b.dest;
        t = 0;
        #3;
        while (!s_ready0) begin
            stalls++;
            t++;
            if (t > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accepted at %0t", $time);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #3;
        end
        q.push_back(b);
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d_left required=0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_b;
        int base_p;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        s_id = '0; s_user = '0; s_dest = '0; rdy_mode = 0;

        // Reset values.
        repeat (3) @(negedge clk);
        #2;
        chk("rst_m_valid", 64'(m_valid0), 64'd0);
        chk("rst_s_ready", 64'(s_ready0), 64'd0);
        chk("rst_level", 64'(lvl0), 64'd0);
        chk("rst_beat_cnt", 64'(beat0), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt0), 64'd0);
        chk("rst_tdata", 64'(m_data0), 64'd0);
        chk("rst_tdest", 64'(m_dest0), 64'd0);
        chk("rst_tlast", 64'(m_last0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("release_s_ready", 64'(s_ready0), 64'd1);
        chk("release_m_valid", 64'(m_valid0), 64'd0);
        mon_en = 1'b1;

        // Single beat, latency 1, rewritten TDEST.
        send(mk(32'hAA, 1'b1, 8'd5), 0);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
`ifndef AXIS_STAGE_LINK_PKT_GATE_EN
        chk("lat1_valid", 64'(m_valid0), 64'd1);
`endif
        chk("lat1_tdata", 64'(m_data0), 64'hAA);
        chk("lat1_tdest", 64'(m_dest0), 64'd2);
        chk("lat1_tdest_u1", 64'(m_dest1), 64'd5);
        repeat (3) @(negedge clk);
        #1;
        chk("single_beat_cnt", 64'(beat0), 64'd1);
        chk("single_pkt_cnt", 64'(pkt0), 64'd1);

        // Backpressure: 6 beats offered into a stalled 4-deep link.
        rdy_mode = 1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(mk(32'h100 + 32'(i), 1'(i == 5), 8'(i)), 0);
                end
                idle();
            end
            begin
                repeat (8) @(negedge clk);
                #1;
                chk("bp_level_full", 64'(lvl0), 64'd4);
                chk("bp_s_ready_low", 64'(s_ready0), 64'd0);
                rdy_mode = 0;
            end
        join
        drain();

        // Streaming: 100 beats in packets of 10.
        base_b = exp_beats;
        base_p = exp_pkts;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            send(mk(DATAW'($urandom), 1'((i % 10) == 9), DESTW'($urandom)), 0);
        end
        idle();
        drain();
`ifndef AXIS_STAGE_LINK_PKT_GATE_EN
        chk("stream_no_stalls", 64'(stalls), 64'd0);
`endif
        chk("stream_beats", 64'(beat0), 64'(CNTW'(base_b + 100)));
        chk("stream_pkts", 64'(pkt0), 64'(CNTW'(base_p + 10)));

        // Random traffic with random sink stalls and source gaps.
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send(mk(DATAW'($urandom), 1'((i == 149) || ($urandom_range(0, 3) == 0)),
                    DESTW'($urandom)), $urandom_range(0, 2));
        end
        idle();
        rdy_mode = 0;
        drain();

        // Asynchronous reset with three beats buffered.
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) send(mk(32'h300 + 32'(i), 1'b0, 8'h33), 0);
        idle();
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 64'(m_valid0), 64'd0);
        chk("arst_level", 64'(lvl0), 64'd0);
        chk("arst_s_ready", 64'(s_ready0), 64'd0);
        chk("arst_beat_cnt", 64'(beat0), 64'd0);
        chk("arst_pkt_cnt", 64'(pkt0), 64'd0);
        q.delete();
        exp_beats = 0;
        exp_pkts = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) send(mk(32'h500 + 32'(i), 1'(i == 4), 8'h55), 0);
        idle();
        drain();
        chk("post_rst_beats", 64'(beat0), 64'd5);
        chk("post_rst_pkts", 64'(pkt0), 64'd1);

`ifdef AXIS_STAGE_LINK_PKT_GATE_EN
        // Store-and-forward: nothing leaves until the TLAST beat is resident.
        send(mk(32'h600, 1'b0, 8'h66), 0);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("gate_closed", 64'(m_valid0), 64'd0);
        end
        send(mk(32'h601, 1'b0, 8'h66), 0);
        send(mk(32'h602, 1'b1, 8'h66), 0);
        idle();
        drain();
        // Four non-last beats fill the link and force the gate open.
        for (int i = 0; i < 4; i++) send(mk(32'h700 + 32'(i), 1'b0, 8'h77), 0);
        idle();
        drain();
        send(mk(32'h704, 1'b1, 8'h77), 0);
        idle();
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
